// File: rtl/seq_divider32.sv
// Radix-2 restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to enable signed division selected by sign_op.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             div0;

  assign div0    = (divisor == '0);
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign a_neg = sign_op & dividend[WIDTH-1];
  assign b_neg = sign_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start && !div0) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic sign_unused;

  assign sign_unused = sign_op;
  assign a_mag       = dividend;
  assign b_mag       = divisor;
  assign q_fix       = quo;
  assign r_fix       = rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = div0 ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && div0) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
          end else if (start) begin
            rem <= '0;
            quo <= a_mag;
            dvs <= b_mag;
            cnt <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          // diff[WIDTH] set means the trial subtract went negative
          cnt <= cnt - CW'(1);
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0]
                             : diff[WIDTH-1:0];
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Iterative radix-2 restoring divider; the subtract/inverse counterpart to the ALU's single-cycle prefix adder datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one bit per clock.
- Sits beside the adder in the MCU ALU and serves DIV/DIVU/REM/REMU through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sign_op  input  1  1 = signed division (effective only with DIV_SIGNED_EN)
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; results valid in this cycle
- quotient  output  WIDTH  result, held until next update
- remainder  output  WIDTH  result, held until next update
- div_zero  output  1  divisor was 0 for the last completed op; held with results

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous, active-low.
  - Reset (including mid-operation) forces state IDLE. busy=0, done=0, quotient=0, remainder=0, div_zero=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- Handshake timing, start accepted at cycle T (start=1 in IDLE):
  - Operands, sign flags and magnitudes are latched.
  - Divisor==0 goes IDLE->DONE. done=1 at T+1, quotient=all ones, remainder=dividend (unmodified), div_zero=1.
  - Otherwise IDLE->CALC; counter loads WIDTH-1.
  - CALC, cycles T+1..T+WIDTH: shift {rem,quo} left one bit and trial-subtract divisor magnitude from rem (WIDTH+1-bit subtract).
    - Non-negative result: rem takes the difference, quotient LSB=1.
    - Negative result: rem is kept, quotient LSB=0.
    - Counter decrements; at 0 go to FIX.
  - FIX, cycle T+WIDTH+1: sign correction.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
    - Results are registered to the outputs; div_zero=0.
  - DONE, cycle T+WIDTH+2 (T+34 for WIDTH=32): done=1 for exactly one cycle, then IDLE.
- Throughput: the next start can be accepted in the IDLE cycle after DONE.
- start while busy=1 (including the DONE cycle) is ignored; no queuing.
- Outputs quotient/remainder/div_zero change only on the FIX->DONE transition or the divide-by-zero IDLE->DONE transition; they hold otherwise, including across a new start until its completion.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Unsigned path: quotient = floor(dividend/divisor), remainder = dividend - quotient*divisor.
- Signed path: truncation toward zero.
  - Overflow case: -2^(WIDTH-1) / -1 gives quotient=0x80000000, remainder=0, computed through the normal path with full latency. The magnitude 2^31 fits the unsigned datapath.
- start and reset deassertion in the same cycle: reset dominates while low; start is sampled normally on the first edge after rst_n rises.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - sign_op=1 selects signed division: magnitude conversion at accept, sign fix in FIX.
  - sign_op=0 gives unsigned division.
- Undefined:
  - sign_op is ignored; every op is unsigned.
  - No negation logic is instantiated.
  - The FIX state still exists and passes values through, so latency is identical in both builds.

Test Plan:
- Unsigned 100/7, start at T -> busy high from T+1; done pulse at T+34 only; quotient=14, remainder=2, div_zero=0.
- 5/0 -> done at T+1, quotient=0xFFFFFFFF, remainder=5, div_zero=1; next op 9/3 -> quotient=3, remainder=0, div_zero=0.
- DIV_SIGNED_EN, sign_op=1:
  - 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Macro undefined, sign_op=1, 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1, latency 34.
- start held high continuously with changing operands -> only ops sampled in IDLE are executed; done pulses every 35 cycles; results match the sampled operands.
- rst_n pulsed low at T+10 of 1000/10 -> immediately busy=0, done=0, quotient=0, remainder=0; no done pulse follows; a new start of 1000/10 completes at +34 with quotient=100, remainder=0.
